data_mem: RTL
=============

DATA_MEM -- requirements
Module: data_mem

Interface
REQ-001 Parameter DEPTH_WORDS, 1024, number of 32-bit words of storage.
REQ-002 Parameter LATENCY, 1, wait cycles between request accept and response, legal 0..7.
REQ-003 clk  input  1  sole clock; all state updates on posedge clk.
REQ-004 reset  input  1  reset is synchronous and active-high.
REQ-005 req_valid  input  1  load/store request present.
REQ-006 req_ready  output  1  block can accept a request this cycle.
REQ-007 req_we  input  1  1 = store, 0 = load.
REQ-008 req_addr  input  32  byte address.
REQ-009 req_funct3  input  3  RV32I size code: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-010 req_wdata  input  32  store data, right-aligned.
REQ-011 rsp_valid  output  1  response present.
REQ-012 rsp_ready  input  1  requester takes response.
REQ-013 rsp_rdata  output  32  load result, extended to 32 bits; 0 for stores and errors.
REQ-014 rsp_err  output  1  request was illegal; no memory effect.

Function
REQ-015 The block SHALL be the responder end of the CPU data-memory port, one transaction outstanding at a time.
REQ-016 FSM states SHALL be IDLE, WAIT, RESP; req_ready = 1 only in IDLE.
REQ-017 Accept SHALL occur on a posedge with req_valid && req_ready; request fields are latched then.
REQ-018 On accept: to RESP if LATENCY = 0, else to WAIT with counter loaded to LATENCY-1; WAIT decrements and moves to RESP when counter is 0, so rsp_valid rises exactly LATENCY+1 cycles after the accept edge.
REQ-019 In RESP, rsp_valid = 1 and rsp_rdata/rsp_err SHALL hold stable until rsp_valid && rsp_ready; that edge returns to IDLE (req_ready = 1 the next cycle).
REQ-020 Stores SHALL commit to memory on the accept edge; loads SHALL read memory on the accept edge; the response only reports.
REQ-021 Byte order is little-endian: B/BU use lane addr[1:0], H/HU use lanes {addr[1],0} and {addr[1],1}, W uses all lanes.
REQ-022 SB/SH SHALL write only the addressed lanes from req_wdata[7:0] / [15:0]; other lanes unchanged.
REQ-023 LB/LH SHALL sign-extend; LBU/LHU SHALL zero-extend; LW returns the word unchanged.
REQ-024 rsp_err = 1 SHALL be set for: halfword with addr[0] = 1; word with addr[1:0] != 0; addr[31:2] >= DEPTH_WORDS; funct3 011, 110, 111; store with funct3[2] = 1.
REQ-025 An erroring request SHALL NOT modify memory, returns rsp_rdata = 0, and has the same timing as a legal one.
REQ-026 req_* inputs outside the accept edge SHALL be ignored; rsp_ready outside RESP SHALL be ignored.

Reset
REQ-027 While reset is high on a posedge, the FSM SHALL go to IDLE, counter to 0, rsp_valid = 0, rsp_rdata = 0, rsp_err = 0, and req_ready SHALL be 0 in the reset cycle and 1 in the first cycle after.
REQ-028 Reset mid-transaction SHALL drop any pending response; a store already accepted stays committed; memory contents are not cleared.

Structure
REQ-029 Package mem_pkg SHALL hold the funct3 size enum, the FSM state enum, and the width constants shared with the CPU.
REQ-030 Combinational sub-module mem_align SHALL generate store byte-enables and shifted write data and perform load lane extraction and extension.

Verification
REQ-031 LATENCY=1: SW 0x10 = 0xDEADBEEF, then LW 0x10 -> rdata 0xDEADBEEF, err 0, rsp_valid 2 cycles after accept.
REQ-032 SB 0x11 data 0x80 over that word -> LW 0x10 = 0xDEAD80EF, LB 0x11 = 0xFFFFFF80, LBU 0x11 = 0x00000080, LHU 0x12 = 0x0000DEAD.
REQ-033 LH 0x13 -> err 1, rdata 0; SW 0x12 data 0 -> err 1, then LW 0x10 still 0xDEAD80EF.
REQ-034 rsp_ready low 5 cycles in RESP -> rsp_valid, rdata, err stable and req_ready 0; after the handshake, req_ready 1 the next cycle.
REQ-035 Reset asserted during WAIT -> rsp_valid 0, no response issued, req_ready 1 first cycle after reset; the earlier store is still readable.
REQ-036 LW at 4*DEPTH_WORDS -> err 1; funct3 011 -> err 1; LATENCY=0 -> rsp_valid the cycle after accept.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared definitions for the CPU data-memory port: word geometry, RV32I
// access sizes, responder FSM states and the size/alignment legality check.
package mem_pkg;

   localparam int unsigned XLEN  = 32;
   localparam int unsigned NBYTE = XLEN / 8;

   typedef enum logic [2:0] {
      F3_B  = 3'b000,
      F3_H  = 3'b001,
      F3_W  = 3'b010,
      F3_BU = 3'b100,
      F3_HU = 3'b101
   } funct3_e;

   typedef enum logic [1:0] {
      S_IDLE,
      S_WAIT,
      S_RESP
   } state_e;

   // Size/alignment legality only; the address range check needs the depth.
   function automatic logic size_err(input logic [2:0] f3,
                                     input logic [1:0] addr_lo,
                                     input logic       we);
      logic e;
      case (f3)
         F3_B:    e = 1'b0;
         F3_BU:   e = we;
         F3_H:    e = addr_lo[0];
         F3_HU:   e = we | addr_lo[0];
         F3_W:    e = (addr_lo != 2'b00);
         default: e = 1'b1;
      endcase
      return e;
   endfunction

endpackage

// File: rtl/mem_align.sv
// Lane steering between the 32-bit storage word and the requester: store
// byte-enables with replicated write data, and load extraction with extension.
module mem_align
   import mem_pkg::*;
(
   input  logic [2:0]      funct3,
   input  logic [1:0]      addr_lo,
   input  logic [XLEN-1:0] wdata,
   input  logic [XLEN-1:0] rword,
   output logic [NBYTE-1:0] be,
   output logic [XLEN-1:0] wdata_sh,
   output logic [XLEN-1:0] rdata_ext
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   always_comb begin
      be       = '0;
      wdata_sh = '0;
      case (funct3)
         F3_B: begin
            be       = 4'b0001 << addr_lo;
            wdata_sh = {4{wdata[7:0]}};
         end
         F3_H: begin
            be       = addr_lo[1] ? 4'b1100 : 4'b0011;
            wdata_sh = {2{wdata[15:0]}};
         end
         F3_W: begin
            be       = '1;
            wdata_sh = wdata;
         end
         default: ;
      endcase
   end

   always_comb begin
      byte_sel  = rword[{addr_lo, 3'b000} +: 8];
      half_sel  = addr_lo[1] ? rword[31:16] : rword[15:0];
      rdata_ext = '0;
      case (funct3)
         F3_B:    rdata_ext = {{24{byte_sel[7]}}, byte_sel};
         F3_BU:   rdata_ext = {24'h0, byte_sel};
         F3_H:    rdata_ext = {{16{half_sel[15]}}, half_sel};
         F3_HU:   rdata_ext = {16'h0, half_sel};
         F3_W:    rdata_ext = rword;
         default: ;
      endcase
   end

endmodule

// File: rtl/data_mem.sv
// Responder end of the CPU data-memory port: one transaction in flight,
// memory effect on the accept edge, response after LATENCY wait cycles.
module data_mem
   import mem_pkg::*;
#(
   parameter int unsigned DEPTH_WORDS = 1024,
   parameter int unsigned LATENCY     = 1
)(
   input  logic            clk,
   input  logic            reset,
   input  logic            req_valid,
   output logic            req_ready,
   input  logic            req_we,
   input  logic [31:0]     req_addr,
   input  logic [2:0]      req_funct3,
   input  logic [31:0]     req_wdata,
   output logic            rsp_valid,
   input  logic            rsp_ready,
   output logic [31:0]     rsp_rdata,
   output logic            rsp_err
);

   localparam int unsigned AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

   logic [XLEN-1:0]  mem [DEPTH_WORDS];
   state_e           state;
   logic [2:0]       cnt;
   logic [XLEN-1:0]  res_q;
   logic             err_q;

   logic [AW-1:0]    idx;
   logic             accept;
   logic             acc_err;
   logic [NBYTE-1:0] be;
   logic [XLEN-1:0]  wdata_sh;
   logic [XLEN-1:0]  rdata_ext;
   logic [XLEN-1:0]  load_res;

   assign req_ready = (state == S_IDLE) && !reset;
   assign accept    = req_valid && req_ready;
   assign idx       = req_addr[AW+1:2];
   assign acc_err   = size_err(req_funct3, req_addr[1:0], req_we)
                    || ({2'b00, req_addr[31:2]} >= DEPTH_WORDS);
   assign load_res  = (acc_err || req_we) ? '0 : rdata_ext;

   mem_align u_align (
      .funct3    (req_funct3),
      .addr_lo   (req_addr[1:0]),
      .wdata     (req_wdata),
      .rword     (mem[idx]),
      .be        (be),
      .wdata_sh  (wdata_sh),
      .rdata_ext (rdata_ext)
   );

   // Storage is deliberately outside reset so contents survive it.
   always_ff @(posedge clk) begin
      if (accept && req_we && !acc_err) begin
         for (int unsigned i = 0; i < NBYTE; i++) begin
            if (be[i]) mem[idx][8*i +: 8] <= wdata_sh[8*i +: 8];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= S_IDLE;
         cnt       <= '0;
         res_q     <= '0;
         err_q     <= 1'b0;
         rsp_valid <= 1'b0;
         rsp_rdata <= '0;
         rsp_err   <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (accept) begin
                  res_q <= load_res;
                  err_q <= acc_err;
                  if (LATENCY == 0) begin
                     state     <= S_RESP;
                     rsp_valid <= 1'b1;
                     rsp_rdata <= load_res;
                     rsp_err   <= acc_err;
                  end else begin
                     state <= S_WAIT;
                     cnt   <= 3'(LATENCY - 1);
                  end
               end
            end
            S_WAIT: begin
               if (cnt == '0) begin
                  state     <= S_RESP;
                  rsp_valid <= 1'b1;
                  rsp_rdata <= res_q;
                  rsp_err   <= err_q;
               end else begin
                  cnt <= cnt - 3'd1;
               end
            end
            S_RESP: begin
               if (rsp_ready) begin
                  state     <= S_IDLE;
                  rsp_valid <= 1'b0;
                  rsp_rdata <= '0;
                  rsp_err   <= 1'b0;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule
